// File: rtl/wishbone_master_sequencer.sv
// wishbone_master_sequencer: single-command Wishbone classic bus master
// with streamed write/read data, address auto-increment and bus timeout.
module wishbone_master_sequencer #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_cmd_stb,
    output logic        o_cmd_rdy,
    input  logic        i_cmd_we,
    input  logic [31:0] i_cmd_adr,
    input  logic [15:0] i_cmd_len,
    input  logic [31:0] i_wr_dat,
    input  logic        i_wr_stb,
    output logic        o_wr_rdy,
    output logic [31:0] o_rd_dat,
    output logic        o_rd_stb,
    input  logic        i_rd_rdy,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_timeout,
    output logic        o_int,
    output logic        o_m_we,
    output logic        o_m_stb,
    output logic        o_m_cyc,
    output logic [3:0]  o_m_sel,
    output logic [31:0] o_m_adr,
    output logic [31:0] o_m_dat,
    input  logic [31:0] i_m_dat,
    input  logic        i_m_ack,
    input  logic        i_m_int
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_WAIT,
        S_BUS,
        S_RD_HOLD,
        S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_we;
    logic [31:0] r_adr;
    logic [15:0] r_len;
    logic [15:0] r_tmo;
    logic [31:0] r_wdat;
    logic [31:0] r_rdat;
    logic        r_timeout;
    logic        r_started;
    logic        r_int_d;

    logic w_cmd_hs;
    logic w_wr_hs;
    logic w_ack;
    logic w_rd_hs;
    logic w_last;
    logic w_tmo_hit;

    assign w_cmd_hs  = (r_state == S_IDLE) & i_cmd_stb;
    assign w_wr_hs   = (r_state == S_WR_WAIT) & i_wr_stb;
    assign w_ack     = (r_state == S_BUS) & i_m_ack;
    assign w_rd_hs   = (r_state == S_RD_HOLD) & i_rd_rdy;
    assign w_last    = (r_len == 16'd1);
    assign w_tmo_hit = (r_state == S_BUS) & ~i_m_ack
                     & (r_tmo == TIMEOUT_CYCLES - 16'd1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (i_cmd_stb) w_next = i_cmd_we ? S_WR_WAIT : S_BUS;
            end
            S_WR_WAIT: begin
                if (i_wr_stb) w_next = S_BUS;
            end
            S_BUS: begin
                if (i_m_ack) begin
                    if (!r_we)       w_next = S_RD_HOLD;
                    else if (w_last) w_next = S_DONE;
                    else             w_next = S_WR_WAIT;
                end else if (w_tmo_hit) begin
                    w_next = S_DONE;
                end
            end
            S_RD_HOLD: begin
                if (i_rd_rdy) w_next = w_last ? S_DONE : S_BUS;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_cmd_rdy = 1'b0;
        o_wr_rdy  = 1'b0;
        o_rd_stb  = 1'b0;
        o_done    = 1'b0;
        o_m_stb   = 1'b0;
        o_m_cyc   = 1'b0;
        unique case (r_state)
            S_IDLE:    o_cmd_rdy = rst;
            S_WR_WAIT: begin
                o_wr_rdy = 1'b1;
                o_m_cyc  = r_started;
            end
            S_BUS: begin
                o_m_stb = 1'b1;
                o_m_cyc = 1'b1;
            end
            S_RD_HOLD: begin
                o_rd_stb = 1'b1;
                o_m_cyc  = 1'b1;
            end
            S_DONE:  o_done = 1'b1;
            default: ;
        endcase
    end

    // r_started keeps CYC framed across WR_WAIT gaps once the first word went out
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_we      <= 1'b0;
            r_adr     <= '0;
            r_len     <= '0;
            r_tmo     <= '0;
            r_wdat    <= '0;
            r_rdat    <= '0;
            r_timeout <= 1'b0;
            r_started <= 1'b0;
            r_int_d   <= 1'b0;
        end else begin
            if (w_cmd_hs) begin
                r_we      <= i_cmd_we;
                r_adr     <= i_cmd_adr;
                r_len     <= (i_cmd_len == 16'd0) ? 16'd1 : i_cmd_len;
                r_timeout <= 1'b0;
            end
            if (w_wr_hs) r_wdat <= i_wr_dat;
            if (w_ack) begin
                r_adr <= {r_adr[31:24], r_adr[23:0] + 24'd1};
                if (r_we) r_len  <= r_len - 16'd1;
                else      r_rdat <= i_m_dat;
            end
            if (w_rd_hs)   r_len     <= r_len - 16'd1;
            if (w_tmo_hit) r_timeout <= 1'b1;
            r_tmo     <= (r_state == S_BUS) ? r_tmo + 16'd1 : 16'd0;
            r_started <= (r_state == S_BUS)
                       | (r_started & (r_state != S_DONE)
                                    & (r_state != S_IDLE));
            r_int_d   <= i_m_int;
        end
    end

    assign o_busy    = (r_state != S_IDLE);
    assign o_timeout = r_timeout;
    assign o_int     = i_m_int & ~r_int_d & rst;
    assign o_m_we    = r_we & o_m_cyc;
    assign o_m_sel   = {4{o_m_stb}};
    assign o_m_adr   = r_adr;
    assign o_m_dat   = r_wdat;
    assign o_rd_dat  = r_rdat;

endmodule

// File: tb/tb_wishbone_master_sequencer.sv
// Bench for wishbone_master_sequencer: directed table, corner sequences
// and random commands checked against a transfer-list model.
`timescale 1ns/1ps
module tb_wishbone_master_sequencer;

    logic        clk;
    logic        rst;
    logic        i_cmd_stb;
    logic        o_cmd_rdy;
    logic        i_cmd_we;
    logic [31:0] i_cmd_adr;
    logic [15:0] i_cmd_len;
    logic [31:0] i_wr_dat;
    logic        i_wr_stb;
    logic        o_wr_rdy;
    logic [31:0] o_rd_dat;
    logic        o_rd_stb;
    logic        i_rd_rdy;
    logic        o_busy;
    logic        o_done;
    logic        o_timeout;
    logic        o_int;
    logic        o_m_we;
    logic        o_m_stb;
    logic        o_m_cyc;
    logic [3:0]  o_m_sel;
    logic [31:0] o_m_adr;
    logic [31:0] o_m_dat;
    logic [31:0] i_m_dat;
    logic        i_m_ack;
    logic        i_m_int;

    wishbone_master_sequencer #(.TIMEOUT_CYCLES(16'd8)) dut (
        .clk(clk), .rst(rst),
        .i_cmd_stb(i_cmd_stb), .o_cmd_rdy(o_cmd_rdy),
        .i_cmd_we(i_cmd_we), .i_cmd_adr(i_cmd_adr), .i_cmd_len(i_cmd_len),
        .i_wr_dat(i_wr_dat), .i_wr_stb(i_wr_stb), .o_wr_rdy(o_wr_rdy),
        .o_rd_dat(o_rd_dat), .o_rd_stb(o_rd_stb), .i_rd_rdy(i_rd_rdy),
        .o_busy(o_busy), .o_done(o_done), .o_timeout(o_timeout),
        .o_int(o_int), .o_m_we(o_m_we), .o_m_stb(o_m_stb),
        .o_m_cyc(o_m_cyc), .o_m_sel(o_m_sel), .o_m_adr(o_m_adr),
        .o_m_dat(o_m_dat), .i_m_dat(i_m_dat), .i_m_ack(i_m_ack),
        .i_m_int(i_m_int)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [31:0] adr;
        logic        we;
        logic [31:0] dat;
        logic [3:0]  sel;
    } xfer_t;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [15:0] len;
        int          maxw;
        int          exp_n;
        logic [31:0] exp_last;
    } vec_t;

    xfer_t       xlog[$];
    logic [31:0] rdq[$];
    logic [31:0] wq[$];
    logic [31:0] wexp[$];

    int errors = 0;
    int checks = 0;

    // environment knobs
    bit ack_en   = 1'b1;
    bit spur_en  = 1'b1;
    bit rdy_hold = 1'b0;
    int rdy_pct  = 100;
    int wr_pct   = 100;
    int max_wait = 0;
    int cur_wait = 0;
    int wcnt     = 0;

    // monitor observations
    int cyc_n = 0;
    int acc_cnt = 0;
    int acc_cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int ack_cyc = 0;
    int stb_cycles = 0;
    int stb_rise_cyc = 0;
    int cyc_gap = 0;
    int sel_err = 0;
    int rd_stb_seen = 0;
    bit done_to = 1'b0;
    bit done_to_before = 1'b0;
    bit prev_to = 1'b0;
    bit prev_stb = 1'b0;
    bit in_cmd = 1'b0;

    // current command context for the model
    logic        c_we;
    logic [31:0] c_adr;
    int          c_n;
    int          d_base;

    function automatic logic [31:0] rd_fn(logic [31:0] a);
        if (a == 32'h0100_0004) return 32'hDEADBEEF;
        return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
    endfunction

    function automatic logic [31:0] nth_adr(logic [31:0] base, int k);
        logic [23:0] lo;
        lo = base[23:0] + 24'(k);
        return {base[31:24], lo};
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // slave, stream host and monitor: drive at negedge, sample before posedge
    initial begin
        i_m_ack  = 1'b0;
        i_m_dat  = '0;
        i_rd_rdy = 1'b0;
        i_wr_stb = 1'b0;
        i_wr_dat = '0;
        forever begin
            @(negedge clk);
            cyc_n++;
            if (o_m_stb && ack_en && wcnt >= cur_wait) begin
                i_m_ack = 1'b1;
                i_m_dat = rd_fn(o_m_adr);
            end else if (o_m_stb) begin
                i_m_ack = 1'b0;
                i_m_dat = $urandom;
            end else begin
                i_m_ack = spur_en ? 1'($urandom_range(0, 1)) : 1'b0;
                i_m_dat = $urandom;
            end
            i_rd_rdy = rdy_hold ? 1'b0 : (int'($urandom_range(0, 99)) < rdy_pct);
            if (wq.size() > 0) begin
                i_wr_stb = (int'($urandom_range(0, 99)) < wr_pct);
                i_wr_dat = wq[0];
            end else begin
                i_wr_stb = 1'b0;
                i_wr_dat = $urandom;
            end
            #4;
            if (o_m_stb) begin
                stb_cycles++;
                if (i_m_ack) begin
                    xlog.push_back({o_m_adr, o_m_we, o_m_dat, o_m_sel});
                    ack_cyc  = cyc_n;
                    wcnt     = 0;
                    cur_wait = int'($urandom_range(0, max_wait));
                end else begin
                    wcnt++;
                end
                if (o_m_sel != 4'hF) sel_err++;
            end else begin
                wcnt = 0;
            end
            if (o_m_stb && !prev_stb) stb_rise_cyc = cyc_n;
            prev_stb = o_m_stb;
            if (o_rd_stb) rd_stb_seen++;
            if (o_rd_stb && i_rd_rdy) rdq.push_back(o_rd_dat);
            if (o_wr_rdy && i_wr_stb) void'(wq.pop_front());
            if (i_cmd_stb && o_cmd_rdy) begin
                acc_cnt++;
                acc_cyc = cyc_n;
            end
            if (o_done) begin
                done_cnt++;
                done_cyc       = cyc_n;
                done_to        = o_timeout;
                done_to_before = prev_to;
            end
            prev_to = o_timeout;
            if (o_m_stb) in_cmd = 1'b1;
            if (!o_busy) in_cmd = 1'b0;
            if (in_cmd && !o_done && !o_m_cyc) cyc_gap++;
        end
    end

    task automatic prep(input logic we, input logic [31:0] adr,
                        input logic [15:0] len, input int maxw);
        logic [31:0] d;
        c_we  = we;
        c_adr = adr;
        c_n   = (len == 16'd0) ? 1 : int'(len);
        xlog.delete();
        rdq.delete();
        wq.delete();
        wexp.delete();
        max_wait = maxw;
        cur_wait = int'($urandom_range(0, maxw));
        if (we) begin
            for (int k = 0; k < c_n; k++) begin
                d = $urandom;
                wexp.push_back(d);
                wq.push_back(d);
            end
        end
        d_base = done_cnt;
    endtask

    task automatic start_cmd(input logic we, input logic [31:0] adr,
                             input logic [15:0] len);
        int a0;
        int g;
        @(negedge clk);
        i_cmd_we  = we;
        i_cmd_adr = adr;
        i_cmd_len = len;
        i_cmd_stb = 1'b1;
        a0 = acc_cnt;
        g  = 0;
        while (acc_cnt == a0 && g < 3000) begin
            @(posedge clk);
            #1;
            g++;
        end
        i_cmd_stb = 1'b0;
        chk("cmd_accept", 64'(acc_cnt != a0), 64'd1);
    endtask

    task automatic wait_done(input int target);
        int g;
        g = 0;
        while (done_cnt < target && g < 3000) begin
            @(posedge clk);
            #1;
            g++;
        end
        chk("done_wait", 64'(done_cnt >= target), 64'd1);
    endtask

    task automatic check_cmd();
        logic [31:0] ea;
        repeat (2) @(posedge clk);
        #1;
        chk("done_pulses", 64'(done_cnt - d_base), 64'd1);
        chk("timeout_clear", 64'(o_timeout), 64'd0);
        chk("xfer_count", 64'(xlog.size()), 64'(c_n));
        for (int k = 0; k < c_n && k < xlog.size(); k++) begin
            ea = nth_adr(c_adr, k);
            chk($sformatf("xfer%0d_adr", k), 64'(xlog[k].adr), 64'(ea));
            chk($sformatf("xfer%0d_we", k), 64'(xlog[k].we), 64'(c_we));
            chk($sformatf("xfer%0d_sel", k), 64'(xlog[k].sel), 64'hF);
            if (c_we)
                chk($sformatf("xfer%0d_wdat", k), 64'(xlog[k].dat), 64'(wexp[k]));
        end
        if (!c_we) begin
            chk("rd_count", 64'(rdq.size()), 64'(c_n));
            for (int k = 0; k < c_n && k < rdq.size(); k++)
                chk($sformatf("rd%0d_dat", k), 64'(rdq[k]), 64'(rd_fn(nth_adr(c_adr, k))));
        end
    endtask

    task automatic run_cmd(input logic we, input logic [31:0] adr,
                           input logic [15:0] len, input int maxw);
        prep(we, adr, len, maxw);
        start_cmd(we, adr, len);
        wait_done(d_base + 1);
        check_cmd();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl[6];
        logic [31:0] hold_d;
        int          bad;
        int          g;
        logic        r_we_v;
        logic [7:0]  hi;
        logic [23:0] lo;

        tbl[0] = '{1'b0, 32'h0100_0004, 16'd1, 0, 1, 32'h0100_0004};
        tbl[1] = '{1'b1, 32'h0200_0010, 16'd3, 1, 3, 32'h0200_0012};
        tbl[2] = '{1'b0, 32'h03FF_FFFF, 16'd2, 0, 2, 32'h0300_0000};
        tbl[3] = '{1'b0, 32'h0400_0000, 16'd0, 2, 1, 32'h0400_0000};
        tbl[4] = '{1'b1, 32'h05FF_FFFE, 16'd3, 0, 3, 32'h0500_0000};
        tbl[5] = '{1'b1, 32'h0600_0000, 16'd0, 1, 1, 32'h0600_0000};

        rst       = 1'b0;
        i_cmd_stb = 1'b0;
        i_cmd_we  = 1'b0;
        i_cmd_adr = '0;
        i_cmd_len = '0;
        i_m_int   = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs_zero",
            64'(|{o_cmd_rdy, o_wr_rdy, o_rd_dat, o_rd_stb, o_busy, o_done,
                  o_timeout, o_int, o_m_we, o_m_stb, o_m_cyc, o_m_sel,
                  o_m_adr, o_m_dat}), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_cmd_rdy", 64'(o_cmd_rdy), 64'd1);

        rdy_pct = 100;
        wr_pct  = 100;
        for (int i = 0; i < 6; i++) begin
            run_cmd(tbl[i].we, tbl[i].adr, tbl[i].len, tbl[i].maxw);
            chk($sformatf("tbl%0d_n", i), 64'(xlog.size()), 64'(tbl[i].exp_n));
            if (xlog.size() > 0)
                chk($sformatf("tbl%0d_last_adr", i),
                    64'(xlog[xlog.size() - 1].adr), 64'(tbl[i].exp_last));
        end

        // single zero-wait read: latency of stb and done
        run_cmd(1'b0, 32'h0100_0004, 16'd1, 0);
        chk("rd_stb_latency", 64'(stb_rise_cyc - acc_cyc), 64'd1);
        chk("rd_done_latency", 64'(done_cyc - ack_cyc), 64'd2);
        if (rdq.size() > 0) chk("rd_deadbeef", 64'(rdq[0]), 64'hDEADBEEF);

        // burst write: done right after final ack
        run_cmd(1'b1, 32'h0200_0010, 16'd3, 0);
        chk("wr_done_latency", 64'(done_cyc - ack_cyc), 64'd1);

        // timeout abort
        ack_en = 1'b0;
        prep(1'b0, 32'h0700_0000, 16'd3, 0);
        g   = stb_cycles;
        bad = rd_stb_seen;
        start_cmd(1'b0, 32'h0700_0000, 16'd3);
        wait_done(d_base + 1);
        repeat (2) @(posedge clk);
        #1;
        chk("tmo_stb_cycles", 64'(stb_cycles - g), 64'd8);
        chk("tmo_flag", 64'(o_timeout), 64'd1);
        chk("tmo_with_done", 64'(done_to), 64'd1);
        chk("tmo_low_before_done", 64'(done_to_before), 64'd0);
        chk("tmo_no_rd_stb", 64'(rd_stb_seen - bad), 64'd0);
        chk("tmo_no_xfer", 64'(xlog.size()), 64'd0);
        chk("tmo_one_done", 64'(done_cnt - d_base), 64'd1);
        ack_en = 1'b1;
        prep(1'b0, 32'h0700_0100, 16'd1, 1);
        start_cmd(1'b0, 32'h0700_0100, 16'd1);
        chk("tmo_cleared_on_accept", 64'(o_timeout), 64'd0);
        wait_done(d_base + 1);
        check_cmd();

        // read backpressure
        rdy_hold = 1'b1;
        prep(1'b0, 32'h0800_0010, 16'd2, 0);
        start_cmd(1'b0, 32'h0800_0010, 16'd2);
        g = 0;
        while (!o_rd_stb && g < 100) begin
            @(posedge clk);
            #1;
            g++;
        end
        chk("bp_rd_stb", 64'(o_rd_stb), 64'd1);
        hold_d = o_rd_dat;
        bad    = 0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (!o_rd_stb || o_rd_dat !== hold_d || o_m_stb) bad++;
        end
        chk("bp_stable", 64'(bad), 64'd0);
        chk("bp_data", 64'(hold_d), 64'(rd_fn(32'h0800_0010)));
        chk("bp_no_new_xfer", 64'(xlog.size()), 64'd1);
        rdy_hold = 1'b0;
        wait_done(d_base + 1);
        check_cmd();

        // command presented while busy is held off
        prep(1'b0, 32'h0A00_0000, 16'd2, 2);
        start_cmd(1'b0, 32'h0A00_0000, 16'd2);
        start_cmd(1'b0, 32'h0B00_0000, 16'd1);
        wait_done(d_base + 2);
        repeat (2) @(posedge clk);
        #1;
        chk("hold_xfers", 64'(xlog.size()), 64'd3);
        if (xlog.size() == 3) chk("hold_b_adr", 64'(xlog[2].adr), 64'h0B00_0000);
        chk("hold_dones", 64'(done_cnt - d_base), 64'd2);

        // random commands against the model
        for (int i = 0; i < 24; i++) begin
            r_we_v  = 1'($urandom_range(0, 1));
            hi      = 8'($urandom);
            lo      = ($urandom_range(0, 3) == 0)
                    ? 24'hFFFFFF - 24'($urandom_range(0, 3))
                    : 24'($urandom);
            rdy_pct = int'($urandom_range(30, 100));
            wr_pct  = int'($urandom_range(30, 100));
            run_cmd(r_we_v, {hi, lo}, 16'($urandom_range(0, 5)),
                    int'($urandom_range(0, 3)));
        end
        rdy_pct = 100;
        wr_pct  = 100;

        // asynchronous reset during a bus cycle
        ack_en = 1'b0;
        prep(1'b0, 32'h0900_0000, 16'd2, 0);
        start_cmd(1'b0, 32'h0900_0000, 16'd2);
        g = 0;
        while (!o_m_stb && g < 50) begin
            @(posedge clk);
            #1;
            g++;
        end
        chk("rst_stb_seen", 64'(o_m_stb), 64'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("rst_async_drop", 64'({o_m_cyc, o_m_stb, o_busy}), 64'd0);
        chk("rst_outputs_zero",
            64'(|{o_cmd_rdy, o_wr_rdy, o_rd_dat, o_rd_stb, o_busy, o_done,
                  o_timeout, o_int, o_m_we, o_m_stb, o_m_cyc, o_m_sel,
                  o_m_adr, o_m_dat}), 64'd0);
        @(negedge clk);
        rst    = 1'b1;
        ack_en = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_release_cmd_rdy", 64'(o_cmd_rdy), 64'd1);

        // interrupt edge
        chk("int_idle", 64'(o_int), 64'd0);
        @(negedge clk);
        i_m_int = 1'b1;
        #1;
        chk("int_rise", 64'(o_int), 64'd1);
        @(posedge clk);
        #1;
        chk("int_one_cycle", 64'(o_int), 64'd0);
        bad = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (o_int) bad++;
        end
        chk("int_no_repeat", 64'(bad), 64'd0);
        @(negedge clk);
        i_m_int = 1'b0;
        #1;
        chk("int_fall_none", 64'(o_int), 64'd0);

        chk("cyc_continuous", 64'(cyc_gap), 64'd0);
        chk("sel_during_stb", 64'(sel_err), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wishbone_master_sequencer.md
# wishbone_master_sequencer

Bus-mastering engine that drives the master port of the Wishbone slave-select interconnect. It accepts a single command (read or write, start address, word count), then issues one Wishbone classic single-cycle transfer per word, auto-incrementing the address within the selected slave's space. It streams write data in and read data out through valid/ready handshakes, and reports completion or bus timeout to its host.

## Interface
Parameters:
- TIMEOUT_CYCLES, 16'd1000: cycles `o_m_stb` may stay high without `i_m_ack` before the command aborts.

Ports:
- clk  in  1  system clock; all logic rising-edge
- rst  in  1  asynchronous, active-low reset
- i_cmd_stb  in  1  command valid
- o_cmd_rdy  out  1  command accepted when `i_cmd_stb & o_cmd_rdy`
- i_cmd_we  in  1  1 = write command, 0 = read command
- i_cmd_adr  in  32  start word address; [31:24] is the slave select
- i_cmd_len  in  16  word count; 0 is treated as 1
- i_wr_dat  in  32  write data word
- i_wr_stb  in  1  write data valid
- o_wr_rdy  out  1  write data accepted when `i_wr_stb & o_wr_rdy`
- o_rd_dat  out  32  read data word
- o_rd_stb  out  1  read data valid
- i_rd_rdy  in  1  read data consumed when `o_rd_stb & i_rd_rdy`
- o_busy  out  1  high from command accept through the DONE state
- o_done  out  1  one-cycle pulse at command end (normal or aborted)
- o_timeout  out  1  sticky; set on abort, cleared on next command accept
- o_int  out  1  one-cycle pulse on each rising edge of `i_m_int`
- o_m_we, o_m_stb, o_m_cyc  out  1 each  Wishbone master controls
- o_m_sel  out  4  always 4'hF while `o_m_stb` is high
- o_m_adr  out  32  transfer address
- o_m_dat  out  32  transfer write data
- i_m_dat  in  32  slave read data
- i_m_ack  in  1  slave acknowledge
- i_m_int  in  1  aggregated slave interrupt

## Operation
- **Reset values:** every output is 0, FSM is in IDLE, and `i_m_int` edge history is 0. An asynchronous reset mid-transfer drops `o_m_cyc` and `o_m_stb` immediately.
- **FSM states:** IDLE, WR_WAIT, BUS, RD_HOLD, DONE.
- **IDLE**
  - `o_cmd_rdy` = 1.
  - On accept, latch `we`, `adr`, and `len` (0 becomes 1) into the remaining-word counter, and clear `o_timeout`.
  - Read command: go to BUS. Write command: go to WR_WAIT.
- **WR_WAIT**
  - `o_wr_rdy` = 1.
  - On handshake, latch `i_wr_dat` into `o_m_dat` and go to BUS.
- **BUS**
  - `o_m_cyc` = `o_m_stb` = 1. `o_m_we` = latched `we`. `o_m_sel` = 4'hF.
  - On `i_m_ack`:
    - Read: capture `i_m_dat` into `o_rd_dat` and go to RD_HOLD.
    - Write: decrement the remaining-word counter. Go to DONE if it reaches 0, else to WR_WAIT.
- **RD_HOLD**
  - `o_rd_stb` = 1.
  - On `i_rd_rdy`, decrement the remaining-word counter. Go to DONE if it reaches 0, else to BUS.
- **DONE:** `o_done` = 1 for one cycle, then return to IDLE.
- **Bus cycle framing**
  - `o_m_cyc` stays high from the first BUS entry until DONE, including WR_WAIT and RD_HOLD between words.
  - `o_m_stb` is high only in BUS.
- **Address increment:** after each acked word, `adr[23:0]` increments by 1 and wraps 24'hFFFFFF → 24'h000000. `adr[31:24]` never changes, so a command never crosses slaves.
- **Timeout**
  - A counter clears on BUS entry and increments each BUS cycle without ack.
  - When it reaches TIMEOUT_CYCLES, drop `o_m_cyc`/`o_m_stb` next cycle, set `o_timeout`, and go to DONE.
  - Remaining words are discarded; no `o_rd_stb` is issued for the aborted word.
- An ack arriving while `o_m_stb` = 0 is ignored.
- `o_int` = `i_m_int` & ~`i_m_int_d`, independent of the FSM.

## Timing
- Command accepted at edge N → `o_m_stb` high from cycle N+1 (read), or from one cycle after the write-data handshake (write).
- Ack at edge M:
  - `o_m_stb` low in cycle M+1.
  - Read: `o_rd_stb` high in cycle M+1.
  - Write with words remaining: `o_wr_rdy` high in cycle M+1.
- Zero-wait-state slave (ack in the first stb cycle), read stream with `i_rd_rdy` tied high: 2 cycles per word.
- `o_done` asserts the cycle after the final ack (write) or the final read handshake (read).
- Timeout: `o_m_stb` high for exactly TIMEOUT_CYCLES cycles; `o_done` and `o_timeout` rise in the same cycle.
- `o_cmd_rdy` is low in every state except IDLE; commands presented while busy are held off, not dropped.

## Test plan
- **Single read:** read command, adr 32'h0100_0004, len 1, slave acks the first stb cycle with 32'hDEADBEEF → one `o_rd_stb` with DEADBEEF, `o_m_adr` = 0100_0004, `o_done` 2 cycles after ack with `i_rd_rdy` = 1.
- **Burst write:** len 3 at 32'h0200_0010, data A/B/C → three stb/ack pairs with addresses 0200_0010/11/12 carrying A/B/C. `o_m_cyc` stays continuously high; `o_m_we` = 1 throughout.
- **Address wrap:** read, len 2 at 32'h03FF_FFFF → `o_m_adr` = 03FF_FFFF, then 0300_0000.
- **Timeout:** TIMEOUT_CYCLES = 8, never ack → `o_m_stb` high for 8 cycles, `o_timeout` = 1, one `o_done` pulse, no `o_rd_stb`. The next accepted command clears `o_timeout`.
- **Read backpressure and len 0:** `i_rd_rdy` held low 5 cycles → `o_rd_dat` stable, no new stb until consumed. A command with len 0 performs exactly one transfer.
- **Reset mid-transfer:** assert `rst` low while `o_m_stb` = 1 → `o_m_cyc`/`o_m_stb`/`o_busy` go 0 without waiting for a clock edge. After release, `o_cmd_rdy` = 1. A separate `i_m_int` 0→1 step produces a single-cycle `o_int`.
